// File: rtl/perf_mon_pkg.sv
// perf_mon_pkg: shared state encoding and default widths for the commit monitor
package perf_mon_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALT, HANG} mon_state_e;
    localparam int CNT_W_DEF       = 32;
    localparam int HALT_REPEAT_DEF = 4;
    localparam int HANG_CYCLES_DEF = 1024;
    localparam int HIST_DEPTH_DEF  = 8;
    localparam int PC_W            = 32;
endpackage

// File: rtl/pc_hist_ring.sv
// pc_hist_ring: ring of the most recent retired PCs, read back relative to the newest entry
module pc_hist_ring #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [W-1:0]             rd_data
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    // write newest PC at wr_ptr and advance; pointer wraps naturally at a power-of-2 depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
        end
    end
    assign rd_data = mem[wr_ptr - AW'(1) - rd_idx];
endmodule

// File: rtl/pipe_commit_monitor.sv
// pipe_commit_monitor: retire-stream perf counters with halt/hang detection; PERF_PC_HISTORY_EN adds a PC history ring
module pipe_commit_monitor
    import perf_mon_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int HALT_REPEAT = HALT_REPEAT_DEF,
    parameter int HANG_CYCLES = HANG_CYCLES_DEF,
    parameter int HIST_DEPTH  = HIST_DEPTH_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [31:0]                   i_pc_debug,
    input  logic                          i_insn_vld,
    input  logic                          i_ctrl,
    input  logic                          i_mispred,
    input  logic                          i_clear,
    input  logic [$clog2(HIST_DEPTH)-1:0] i_hist_idx,
    output logic [CNT_W-1:0]              o_cycle_cnt,
    output logic [CNT_W-1:0]              o_insn_cnt,
    output logic [CNT_W-1:0]              o_ctrl_cnt,
    output logic [CNT_W-1:0]              o_mispred_cnt,
    output logic [31:0]                   o_last_pc,
    output logic [1:0]                    o_state,
    output logic                          o_halt,
    output logic                          o_hang,
    output logic [31:0]                   o_hist_pc
);
    localparam int RW = $clog2(HALT_REPEAT + 1);
    localparam int IW = $clog2(HANG_CYCLES + 1);
    mon_state_e    state, state_nxt;
    logic [RW-1:0] rep_cnt, rep_nxt;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic          ret, run_cyc;
    // retire qualification, repeat/idle look-ahead and next state; clear wins over everything
    always_comb begin
        ret       = i_insn_vld && (state == IDLE || state == RUN);
        run_cyc   = state == RUN || ret;
        rep_nxt   = (i_pc_debug == o_last_pc && rep_cnt != '0) ? rep_cnt + RW'(1) : RW'(1);
        idle_nxt  = ret ? '0 : idle_cnt + IW'(1);
        state_nxt = state;
        if (i_clear)
            state_nxt = IDLE;
        else if (ret)
            state_nxt = (rep_nxt == RW'(HALT_REPEAT)) ? HALT : RUN;
        else if (state == RUN && idle_nxt == IW'(HANG_CYCLES))
            state_nxt = HANG;
    end
    // state register with registered halt/hang flags
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state  <= IDLE;
            o_halt <= 1'b0;
            o_hang <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_halt <= state_nxt == HALT;
            o_hang <= state_nxt == HANG;
        end
    end
    // saturating event counters plus the repeat/idle trackers behind halt and hang
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset || i_clear) begin
            o_cycle_cnt   <= '0;
            o_insn_cnt    <= '0;
            o_ctrl_cnt    <= '0;
            o_mispred_cnt <= '0;
            o_last_pc     <= '0;
            rep_cnt       <= '0;
            idle_cnt      <= '0;
        end else begin
            if (run_cyc) o_cycle_cnt <= o_cycle_cnt + CNT_W'(!(&o_cycle_cnt));
            if (ret) begin
                o_insn_cnt    <= o_insn_cnt + CNT_W'(!(&o_insn_cnt));
                o_ctrl_cnt    <= o_ctrl_cnt + CNT_W'(i_ctrl && !(&o_ctrl_cnt));
                o_mispred_cnt <= o_mispred_cnt + CNT_W'(i_mispred && !(&o_mispred_cnt));
                o_last_pc     <= i_pc_debug;
                rep_cnt       <= rep_nxt;
                idle_cnt      <= '0;
            end else if (state == RUN) begin
                idle_cnt <= idle_nxt;
            end
        end
    end
    assign o_state = state;
`ifdef PERF_PC_HISTORY_EN
    pc_hist_ring #(
        .DEPTH(HIST_DEPTH),
        .W    (PC_W)
    ) u_hist (
        .clk    (i_clk),
        .rst_n  (i_reset),
        .wr_en  (ret && !i_clear),
        .wr_data(i_pc_debug),
        .rd_idx (i_hist_idx),
        .rd_data(o_hist_pc)
    );
`else
    logic unused_hist_idx;
    assign unused_hist_idx = ^i_hist_idx;
    assign o_hist_pc       = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_commit_monitor.sv
// tb_pipe_commit_monitor: directed checks of counters, halt, hang, clear, reset, history and saturation
module tb_pipe_commit_monitor;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] pc_debug = 0;
    logic        insn_vld = 0, ctrl = 0, mispred = 0, clear = 0;
    logic [2:0]  hist_idx = 0;
    logic [31:0] cycle_cnt, insn_cnt, ctrl_cnt, mispred_cnt, last_pc, hist_pc;
    logic [1:0]  state;
    logic        halt, hang;
    logic [31:0] s_pc = 0;
    logic        s_vld = 0;
    logic        s_zero = 0;
    logic [2:0]  s_idx = 0;
    logic [3:0]  s_cycle, s_insn, s_ctrl, s_mis;
    logic [31:0] s_last, s_hist;
    logic [1:0]  s_state;
    logic        s_halt, s_hang;
    logic [31:0] exp_h0, exp_h7;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    pipe_commit_monitor #(.CNT_W(32), .HALT_REPEAT(4), .HANG_CYCLES(16), .HIST_DEPTH(8)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_pc_debug(pc_debug), .i_insn_vld(insn_vld),
        .i_ctrl(ctrl), .i_mispred(mispred), .i_clear(clear), .i_hist_idx(hist_idx),
        .o_cycle_cnt(cycle_cnt), .o_insn_cnt(insn_cnt), .o_ctrl_cnt(ctrl_cnt),
        .o_mispred_cnt(mispred_cnt), .o_last_pc(last_pc), .o_state(state),
        .o_halt(halt), .o_hang(hang), .o_hist_pc(hist_pc)
    );

    pipe_commit_monitor #(.CNT_W(4), .HALT_REPEAT(4), .HANG_CYCLES(16), .HIST_DEPTH(8)) dut_sat (
        .i_clk(clk), .i_reset(rst_n), .i_pc_debug(s_pc), .i_insn_vld(s_vld),
        .i_ctrl(s_vld), .i_mispred(s_zero), .i_clear(s_zero), .i_hist_idx(s_idx),
        .o_cycle_cnt(s_cycle), .o_insn_cnt(s_insn), .o_ctrl_cnt(s_ctrl),
        .o_mispred_cnt(s_mis), .o_last_pc(s_last), .o_state(s_state),
        .o_halt(s_halt), .o_hang(s_hang), .o_hist_pc(s_hist)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic vld, input logic [31:0] pc, input logic ct, input logic mp, input logic clr);
        insn_vld = vld; pc_debug = pc; ctrl = ct; mispred = mp; clear = clr;
        @(posedge clk); #1;
        insn_vld = 0; ctrl = 0; mispred = 0; clear = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_insn", insn_cnt, 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_last", last_pc, 0);
        chk("rst_flags", {30'd0, halt, hang}, 0);
        rst_n = 1;
        repeat (5) step(0, 0, 0, 0, 0);
        chk("idle_cycle", cycle_cnt, 0);
        chk("idle_state", 32'(state), 0);
        for (int i = 0; i < 10; i++) step(1, 32'(i * 4), 0, 0, 0);
        chk("p1_state", 32'(state), 1);
        chk("p1_insn", insn_cnt, 10);
        chk("p1_cycle", cycle_cnt, 10);
        chk("p1_last", last_pc, 32'h24);
        step(1, 32'h28, 1, 0, 0);
        step(1, 32'h2c, 1, 1, 0);
        step(1, 32'h30, 1, 0, 0);
        step(0, 32'h0, 0, 1, 0);
        step(0, 32'h0, 1, 1, 0);
        chk("p2_ctrl", ctrl_cnt, 3);
        chk("p2_mispred", mispred_cnt, 1);
        chk("p2_insn", insn_cnt, 13);
        chk("p2_cycle", cycle_cnt, 15);
        repeat (13) step(0, 0, 0, 0, 0);
        chk("idle15_state", 32'(state), 1);
        step(1, 32'h34, 0, 0, 0);
        chk("idle_rearm_state", 32'(state), 1);
        chk("idle_rearm_cycle", cycle_cnt, 29);
        for (int i = 0; i < 3; i++) step(1, 32'h40, 0, 0, 0);
        chk("halt3_state", 32'(state), 1);
        step(1, 32'h40, 0, 0, 0);
        chk("halt_state", 32'(state), 2);
        chk("halt_flag", {31'd0, halt}, 1);
        chk("halt_insn", insn_cnt, 18);
        chk("halt_cycle", cycle_cnt, 33);
        step(1, 32'h44, 1, 1, 0);
        step(1, 32'h40, 1, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        chk("halt_frz_insn", insn_cnt, 18);
        chk("halt_frz_cycle", cycle_cnt, 33);
        chk("halt_frz_ctrl", ctrl_cnt, 3);
        chk("halt_frz_last", last_pc, 32'h40);
        step(1, 32'h50, 1, 1, 1);
        chk("clr_state", 32'(state), 0);
        chk("clr_insn", insn_cnt, 0);
        chk("clr_cycle", cycle_cnt, 0);
        chk("clr_ctrl", ctrl_cnt, 0);
        chk("clr_mis", mispred_cnt, 0);
        chk("clr_last", last_pc, 0);
        chk("clr_halt", {31'd0, halt}, 0);
        step(1, 32'h80, 0, 0, 0);
        repeat (15) step(0, 0, 0, 0, 0);
        chk("hang15_state", 32'(state), 1);
        step(0, 0, 0, 0, 0);
        chk("hang_state", 32'(state), 3);
        chk("hang_flag", {31'd0, hang}, 1);
        chk("hang_cycle", cycle_cnt, 17);
        step(1, 32'h84, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        chk("hang_frz_insn", insn_cnt, 1);
        chk("hang_frz_cycle", cycle_cnt, 17);
        chk("hang_sticky", 32'(state), 3);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 32'(32'h200 + i * 4), 0, 0, 0);
        chk("pre_rst_insn", insn_cnt, 3);
        #3 rst_n = 0;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_insn", insn_cnt, 0);
        chk("arst_cycle", cycle_cnt, 0);
        chk("arst_last", last_pc, 0);
        @(posedge clk); #1;
        rst_n = 1;
        repeat (20) step(0, 0, 0, 0, 0);
        chk("idle_no_timeout", 32'(state), 0);
        hist_idx = 0; #1;
        chk("hist_unwritten", hist_pc, 0);
        for (int i = 0; i < 10; i++) step(1, 32'(32'h100 + i * 4), 0, 0, 0);
        chk("hist_run_insn", insn_cnt, 10);
`ifdef PERF_PC_HISTORY_EN
        exp_h0 = 32'h124; exp_h7 = 32'h108;
`else
        exp_h0 = 32'h0; exp_h7 = 32'h0;
`endif
        hist_idx = 0; #1;
        chk("hist_idx0", hist_pc, exp_h0);
        hist_idx = 7; #1;
        chk("hist_idx7", hist_pc, exp_h7);
        for (int i = 0; i < 20; i++) begin
            s_vld = 1; s_pc = 32'(i * 4);
            @(posedge clk); #1;
        end
        s_vld = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("sat_insn", 32'(s_insn), 15);
        chk("sat_cycle", 32'(s_cycle), 15);
        chk("sat_ctrl", 32'(s_ctrl), 15);
        chk("sat_state", 32'(s_state), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
